// File: rtl/pt5_unpack_seq.sv
// pt5_unpack_seq: PT-5 byte fetch and trit sequencer; `PT5_INVALID_CHECK_EN adds the sticky invalid-byte err flag
module pt5_unpacker (
  input  logic [7:0] packed_byte,
  output logic [9:0] trits
);
  genvar i;
  for (i = 0; i < 5; i++) begin : g_t
    assign trits[2*i +: 2] = 2'((packed_byte / 8'(3**i)) % 8'd3);
  end
endmodule

module pt5_unpack_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] trit_count,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [1:0]       m_trit,
  output logic             m_last,
  output logic             busy,
  output logic             done,
  output logic             err
);
  typedef enum logic [1:0] {IDLE, FETCH, EMIT, DONE} state_t;
  state_t state;
  logic [7:0] byte_r;
  logic [2:0] idx;
  logic [CNT_W-1:0] rem;
  logic [9:0] trits;
  logic [1:0] raw;
  pt5_unpacker u_unp (.packed_byte(byte_r), .trits(trits));
  always_comb raw = idx == 3'd0 ? trits[1:0] : idx == 3'd1 ? trits[3:2] : idx == 3'd2 ? trits[5:4] :
                    idx == 3'd3 ? trits[7:6] : trits[9:8];
  assign s_ready = state == FETCH || (state == EMIT && m_ready && idx == 3'd4 && rem > CNT_W'(1));
  assign m_valid = state == EMIT;
  assign m_last  = m_valid && rem == CNT_W'(1);
  assign busy    = state != IDLE;
  assign done    = state == DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      byte_r <= '0;
      idx    <= '0;
      rem    <= '0;
    end else
      case (state)
        IDLE: if (start) begin
          rem   <= trit_count;
          state <= trit_count == '0 ? DONE : FETCH;
        end
        FETCH: if (s_valid) begin
          byte_r <= s_data;
          idx    <= '0;
          state  <= EMIT;
        end
        EMIT: if (m_ready) begin
          rem <= rem - CNT_W'(1);
          idx <= idx + 3'd1;
          if (rem == CNT_W'(1)) state <= DONE;
          else if (idx == 3'd4) begin
            if (s_valid) begin
              byte_r <= s_data;
              idx    <= '0;
            end else state <= FETCH;
          end
        end
        DONE: state <= IDLE;
      endcase
`ifdef PT5_INVALID_CHECK_EN
  logic err_r;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_r <= 1'b0;
    else if (state == IDLE && start && trit_count != '0) err_r <= 1'b0;
    else if (s_valid && s_ready && s_data > 8'd242) err_r <= 1'b1;
  assign err    = err_r;
  assign m_trit = byte_r > 8'd242 ? 2'd1 : raw;
`else
  assign err    = 1'b0;
  assign m_trit = raw;
`endif
endmodule

// File: tb/tb_pt5_unpack_seq.sv
// tb_pt5_unpack_seq: directed bench with a base-3 trit model and per-cycle output checker
module tb_pt5_unpack_seq;
  logic clk = 0, rst_n = 0, start = 0, s_valid = 0, m_ready = 0;
  logic [15:0] trit_count = 0;
  logic [7:0] s_data = 0;
  logic s_ready, m_valid, m_last, busy, done, err;
  logic [1:0] m_trit;
  int tests = 0, fails = 0, cyc = 0, bytes_used = 0, sr_cnt = 0, done_cnt = 0, w = 0, snap = 0;
  int src_q[$], exp_t[$], got_t[$], got_cyc[$];
  bit exp_l[$], got_sr[$];
  bit pend_done = 0, prev_stall = 0, prev_last = 0, hs = 0, cl = 0;
  logic [1:0] prev_trit = 0;
  int ct = 0;

  pt5_unpack_seq #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .trit_count(trit_count),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_trit(m_trit), .m_last(m_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int digit(int b, int k);
    int p = 1;
    for (int j = 0; j < k; j++) p *= 3;
`ifdef PT5_INVALID_CHECK_EN
    if (b > 242) return 1;
`endif
    return (b / p) % 3;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  task automatic chk_seq(input string nm, input int n, input logic [63:0] pat);
    logic [63:0] gp = 0;
    chk({nm, "_len"}, got_t.size(), n);
    for (int k = 0; k < got_t.size(); k++) gp = (gp << 4) | 64'(got_t[k]);
    chk(nm, gp, pat);
  endtask

  task automatic start_job(input int n);
    int b[$];
    b = src_q;
    exp_t.delete(); exp_l.delete(); got_t.delete(); got_cyc.delete(); got_sr.delete();
    bytes_used = 0;
    for (int k = 0; k < n; k++) begin
      exp_t.push_back(digit(b[k/5], k % 5));
      exp_l.push_back(k == n - 1);
    end
    @(posedge clk); #1 start = 1; trit_count = 16'(n);
    @(posedge clk); #1 start = 0;
  endtask

  task automatic wait_done(input string nm, output int wt);
    wt = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (done) begin wt = i; break; end
    end
    tests++;
    if (wt < 0) begin
      fails++;
      $display("FAIL %s_timeout: got no done expected done within 300 cycles", nm);
    end
  endtask

  // byte source: pops a byte whenever the sequencer took it on the previous edge
  initial forever begin
    @(posedge clk);
    cyc++;
    hs = s_valid && s_ready;
    #1;
    if (hs && src_q.size() > 0) begin
      void'(src_q.pop_front());
      bytes_used++;
    end
    s_valid = src_q.size() > 0;
    s_data = src_q.size() > 0 ? 8'(src_q[0]) : 8'h00;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      pend_done = 0;
      prev_stall = 0;
    end else begin
      tests++;
      if (done !== pend_done) begin
        fails++;
        $display("FAIL done_timing: got %0b expected %0b at cycle %0d", done, pend_done, cyc);
      end
      if (done) done_cnt++;
      if (prev_stall) begin
        tests++;
        if (m_trit !== prev_trit || m_last !== prev_last) begin
          fails++;
          $display("FAIL stall_hold: got %0d/%0b expected %0d/%0b", m_trit, m_last, prev_trit, prev_last);
        end
      end
      pend_done = 0;
      if (s_ready) sr_cnt++;
      if (m_valid && m_ready) begin
        got_t.push_back(int'(m_trit));
        got_cyc.push_back(cyc);
        got_sr.push_back(s_ready);
        tests++;
        if (exp_t.size() == 0) begin
          fails++;
          $display("FAIL extra_trit: got trit %0d expected none", m_trit);
        end else begin
          ct = exp_t.pop_front();
          cl = exp_l.pop_front();
          if (int'(m_trit) != ct || m_last !== cl) begin
            fails++;
            $display("FAIL trit: got %0d last %0b expected %0d last %0b", m_trit, m_last, ct, cl);
          end
          pend_done = cl;
        end
      end
      if (start && !busy && trit_count == 0) pend_done = 1;
      prev_stall = m_valid && !m_ready;
      prev_trit = m_trit;
      prev_last = m_last;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_trit", m_trit, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(posedge clk); #1 rst_n = 1;

    m_ready = 1;
    src_q.push_back(8'h05);
    start_job(5);
    chk("t1_s_ready_k1", s_ready, 1);
    wait_done("t1", w);
    chk_seq("t1_trits", 5, 64'h21000);
    chk("t1_bytes", bytes_used, 1);
    @(negedge clk);
    chk("t1_busy_after", busy, 0);

    src_q.push_back(8'h00); src_q.push_back(8'hF2);
    start_job(10);
    wait_done("t2", w);
    chk_seq("t2_trits", 10, 64'h0000022222);
    chk("t2_bytes", bytes_used, 2);
    chk("t2_rate", got_cyc[9] - got_cyc[0], 9);
    chk("t2_sready_trit4", got_sr[4], 1);
    chk("t2_sready_trit3", got_sr[3], 0);
    chk("t2_sready_trit9", got_sr[9], 0);

    src_q.push_back(8'h79); src_q.push_back(8'h00); src_q.push_back(8'h55);
    start_job(7);
    wait_done("t3", w);
    chk_seq("t3_trits", 7, 64'h1111100);
    chk("t3_bytes", bytes_used, 2);
    chk("t3_left", src_q.size(), 1);
    src_q.delete();

    @(posedge clk); #1 sr_cnt = 0;
    start_job(0);
    wait_done("t4_zero", w);
    chk("t4_zero_latency", w, 0);
    chk("t4_zero_trits", got_t.size(), 0);
    chk("t4_zero_sready", sr_cnt, 0);
    chk("t4_zero_bytes", bytes_used, 0);

    m_ready = 0;
    src_q.push_back(8'h05);
    start_job(5);
    repeat (3) @(posedge clk);
    #1 start = 1; trit_count = 0;
    @(posedge clk); #1 start = 0; m_ready = 1;
    snap = done_cnt;
    wait_done("t4_busy_start", w);
    repeat (3) @(negedge clk);
    chk_seq("t4_busy_trits", 5, 64'h21000);
    chk("t4_busy_bytes", bytes_used, 1);
    chk("t4_busy_dones", done_cnt - snap, 1);

    src_q.push_back(8'h05); src_q.push_back(8'h79);
    start_job(7);
    @(posedge clk); #1 m_ready = 1;
    @(posedge clk); #1 m_ready = 0;
    @(posedge clk); #1 m_ready = 0;
    @(posedge clk); #1 m_ready = 1;
    wait_done("t5_stall", w);
    chk_seq("t5_stall_trits", 7, 64'h2100011);
    chk("t5_stall_bytes", bytes_used, 2);

    src_q.push_back(8'hF2);
    start_job(5);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #2;
      if (got_t.size() >= 2) break;
    end
    chk("t5_rst_third_trit", got_t.size(), 2);
    rst_n = 0;
    #1;
    chk("t5_rst_m_valid", m_valid, 0);
    chk("t5_rst_s_ready", s_ready, 0);
    chk("t5_rst_m_trit", m_trit, 0);
    chk("t5_rst_m_last", m_last, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0);
    exp_t.delete(); exp_l.delete(); src_q.delete();
    snap = done_cnt;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    repeat (4) @(posedge clk);
    #1;
    chk("t5_rst_no_done", done_cnt - snap, 0);
    chk("t5_rst_idle", busy, 0);

    src_q.push_back(8'hFF);
    start_job(5);
    wait_done("t6", w);
`ifdef PT5_INVALID_CHECK_EN
    chk_seq("t6_trits", 5, 64'h11111);
    chk("t6_err", err, 1);
`else
    chk_seq("t6_trits", 5, 64'h01100);
    chk("t6_err", err, 0);
`endif
    chk("t6_bytes", bytes_used, 1);
    src_q.push_back(8'h00);
    start_job(5);
    chk("t6_err_cleared", err, 0);
    wait_done("t6b", w);
    chk_seq("t6b_trits", 5, 64'h00000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
